// File: rtl/sd_host_pkg.sv
// Shared SD host definitions: FSM encoding, response lengths, CRC7 polynomial
// and the control word latched when a response capture is armed.
package sd_host_pkg;

  // Response capture FSM encoding
  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_WAIT_START = 3'd1;
  localparam logic [2:0] ST_RECV       = 3'd2;
  localparam logic [2:0] ST_CHECK      = 3'd3;
  localparam logic [2:0] ST_WRITE      = 3'd4;
  localparam logic [2:0] ST_DONE       = 3'd5;

  // Frame geometry on the CMD line
  localparam int unsigned RESP_SHORT_LEN = 48;
  localparam int unsigned RESP_LONG_LEN  = 136;
  localparam int unsigned RESP_HDR_LEN   = 8;   // R2 header bits excluded from CRC
  localparam int unsigned RESP_TAIL_LEN  = 8;   // CRC7 + end bit

  // x^7 + x^3 + 1
  localparam logic [6:0] CRC7_POLY = 7'h09;

  // Control inputs captured on an accepted start
  typedef struct packed {
    logic       resp_long;
    logic       crc_check_en;
    logic       idx_check_en;
    logic [5:0] cmd_index;
  } resp_ctl_t;

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7+x^3+1), MSB-first, initial value 0.
// Ports: clk, rst (sync, active-high), clr (restart at 0), en (advance one
// bit), bit_in (data bit), crc (current remainder).
module sd_crc7
  import sd_host_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [6:0] crc
);

  logic fb;

  assign fb = bit_in ^ crc[6];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      crc <= '0;
    end else if (en) begin
      crc <= {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    end
  end

endmodule

// File: rtl/sd_resp_capture.sv
// Captures an SD command response from the CMD line, checks start/end/index/
// CRC7, and writes the payload into the Response register with an ack handshake.
// Ports:
//   clk, rst                      clock, sync active-high reset
//   start, resp_long, crc_check_en, idx_check_en, cmd_index
//                                 arm request and per-command controls
//   bit_strobe, cmd_in            sampled CMD line bit and its valid strobe
//   resp_ack                      Response register confirms contents
//   resp_data, resp_wr_en         payload and enable to the Response register
//   busy, done                    status, done is a 1-cycle pulse
//   timeout_err, crc_err, end_err, idx_err  sticky until next accepted start
module sd_resp_capture
  import sd_host_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned NCR_MAX    = 64,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  resp_long,
  input  logic                  crc_check_en,
  input  logic                  idx_check_en,
  input  logic [5:0]            cmd_index,
  input  logic                  bit_strobe,
  input  logic                  cmd_in,
  input  logic                  resp_ack,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_wr_en,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err,
  output logic                  crc_err,
  output logic                  end_err,
  output logic                  idx_err
);

  localparam int unsigned SHREG_W = 128;

  logic [2:0]            state_q, state_d;
  resp_ctl_t             ctl_q, ctl_d;
  logic [CNT_W-1:0]      tmo_q, tmo_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [SHREG_W-1:0]    shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  wr_en_q, wr_en_d;
  logic                  wr_seen_q, wr_seen_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  tmo_err_q, tmo_err_d;
  logic                  crc_err_q, crc_err_d;
  logic                  end_err_q, end_err_d;
  logic                  idx_err_q, idx_err_d;

  logic                  crc_clr_c;
  logic                  crc_en_c;
  logic [6:0]            crc_val;
  logic [CNT_W-1:0]      bit_num;
  logic [CNT_W-1:0]      frame_len;

  // True when 1-based bit position n of the frame feeds the CRC
  function automatic logic crc_covers(input logic is_long, input logic [CNT_W-1:0] n);
    if (is_long) begin
      return (n >= CNT_W'(RESP_HDR_LEN + 1)) && (n <= CNT_W'(RESP_LONG_LEN - RESP_TAIL_LEN));
    end
    return (n >= CNT_W'(1)) && (n <= CNT_W'(RESP_SHORT_LEN - RESP_TAIL_LEN));
  endfunction

  sd_crc7 u_crc7 (
    .clk    (clk),
    .rst    (rst),
    .clr    (crc_clr_c),
    .en     (crc_en_c),
    .bit_in (cmd_in),
    .crc    (crc_val)
  );

  assign bit_num   = bit_cnt_q + CNT_W'(1);
  assign frame_len = ctl_q.resp_long ? CNT_W'(RESP_LONG_LEN) : CNT_W'(RESP_SHORT_LEN);

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    ctl_d     = ctl_q;
    tmo_d     = tmo_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    wr_en_d   = wr_en_q;
    wr_seen_d = wr_seen_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    tmo_err_d = tmo_err_q;
    crc_err_d = crc_err_q;
    end_err_d = end_err_q;
    idx_err_d = idx_err_q;
    crc_clr_c = 1'b0;
    crc_en_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ctl_d     = '{resp_long: resp_long, crc_check_en: crc_check_en,
                        idx_check_en: idx_check_en, cmd_index: cmd_index};
          tmo_d     = '0;
          bit_cnt_d = '0;
          shreg_d   = '0;
          tmo_err_d = 1'b0;
          crc_err_d = 1'b0;
          end_err_d = 1'b0;
          idx_err_d = 1'b0;
          crc_clr_c = 1'b1;
          busy_d    = 1'b1;
          state_d   = ST_WAIT_START;
        end
      end

      ST_WAIT_START: begin
        if (bit_strobe) begin
          if (!cmd_in) begin
            shreg_d   = {shreg_q[SHREG_W-2:0], cmd_in};
            bit_cnt_d = CNT_W'(1);
            crc_en_c  = crc_covers(ctl_q.resp_long, CNT_W'(1));
            state_d   = ST_RECV;
          end else if (tmo_q + CNT_W'(1) == CNT_W'(NCR_MAX)) begin
            tmo_d     = tmo_q + CNT_W'(1);
            tmo_err_d = 1'b1;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            state_d   = ST_DONE;
          end else begin
            tmo_d = tmo_q + CNT_W'(1);
          end
        end
      end

      ST_RECV: begin
        if (bit_strobe) begin
          shreg_d   = {shreg_q[SHREG_W-2:0], cmd_in};
          bit_cnt_d = bit_num;
          crc_en_c  = crc_covers(ctl_q.resp_long, bit_num);
          if (bit_num == frame_len) begin
            state_d = ST_CHECK;
          end
        end
      end

      ST_CHECK: begin
        end_err_d = ~shreg_q[0];
        crc_err_d = ctl_q.crc_check_en & (crc_val != shreg_q[7:1]);
        idx_err_d = ctl_q.idx_check_en & ~ctl_q.resp_long &
                    (shreg_q[45:40] != ctl_q.cmd_index);
        if (ctl_q.resp_long) begin
          data_d = DATA_WIDTH'({8'h00, shreg_q[127:8]});
        end else begin
          data_d = DATA_WIDTH'({96'h0, shreg_q[39:8]});
        end
        wr_en_d   = 1'b1;
        wr_seen_d = 1'b0;
        state_d   = ST_WRITE;
      end

      // Ack is only trusted once the register has seen the enable for a cycle
      ST_WRITE: begin
        if (wr_seen_q && resp_ack) begin
          wr_en_d   = 1'b0;
          wr_seen_d = 1'b0;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = ST_DONE;
        end else begin
          wr_seen_d = 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ctl_q     <= '0;
      tmo_q     <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_seen_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tmo_err_q <= 1'b0;
      crc_err_q <= 1'b0;
      end_err_q <= 1'b0;
      idx_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctl_q     <= ctl_d;
      tmo_q     <= tmo_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      wr_en_q   <= wr_en_d;
      wr_seen_q <= wr_seen_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      tmo_err_q <= tmo_err_d;
      crc_err_q <= crc_err_d;
      end_err_q <= end_err_d;
      idx_err_q <= idx_err_d;
    end
  end

  assign resp_data   = data_q;
  assign resp_wr_en  = wr_en_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = tmo_err_q;
  assign crc_err     = crc_err_q;
  assign end_err     = end_err_q;
  assign idx_err     = idx_err_q;

endmodule

// File: tb/tb_sd_resp_capture.sv
// Scoreboard bench for sd_resp_capture: each response is queued with its
// expected payload, write length and error flags, and checked on done.
module tb_sd_resp_capture;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         resp_long;
  logic         crc_check_en;
  logic         idx_check_en;
  logic [5:0]   cmd_index;
  logic         bit_strobe;
  logic         cmd_in;
  logic         resp_ack = 1'b0;
  logic [127:0] resp_data;
  logic         resp_wr_en;
  logic         busy;
  logic         done;
  logic         timeout_err;
  logic         crc_err;
  logic         end_err;
  logic         idx_err;

  typedef struct {
    logic [127:0] data;
    logic         wr;
    int           cyc;
    logic [3:0]   errs;   // {timeout, crc, end, idx}
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   done_cnt = 0;
  int   exp_done = 0;
  int   wr_cycles = 0;
  int   ack_dly  = 1;
  logic [127:0] wr_data = '0;
  logic done_prev = 1'b0;

  sd_resp_capture dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .resp_long    (resp_long),
    .crc_check_en (crc_check_en),
    .idx_check_en (idx_check_en),
    .cmd_index    (cmd_index),
    .bit_strobe   (bit_strobe),
    .cmd_in       (cmd_in),
    .resp_ack     (resp_ack),
    .resp_data    (resp_data),
    .resp_wr_en   (resp_wr_en),
    .busy         (busy),
    .done         (done),
    .timeout_err  (timeout_err),
    .crc_err      (crc_err),
    .end_err      (end_err),
    .idx_err      (idx_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // CRC7 as polynomial long division of msg(x)*x^7 by x^7+x^3+1
  function automatic logic [6:0] crc7_ref(input logic [119:0] msg, input int n);
    logic [126:0] w;
    w = 127'(msg) << 7;
    for (int i = n + 6; i >= 7; i--) begin
      if (w[i]) w[i -: 8] = w[i -: 8] ^ 8'h89;
    end
    return w[6:0];
  endfunction

  function automatic logic [47:0] mk_short(input logic [5:0] idx, input logic [31:0] arg,
                                           input logic good_crc, input logic end_b);
    logic [39:0] body;
    logic [6:0]  c;
    body = {2'b00, idx, arg};
    c = good_crc ? crc7_ref(120'(body), 40) : 7'h7F;
    return {body, c, end_b};
  endfunction

  // Monitor: tracks the write phase, acks the register, scores on done
  always @(negedge clk) begin
    if (resp_wr_en) begin
      if (wr_cycles == 0) wr_data = resp_data;
      else chk("wr_data_stable", resp_data, wr_data);
      wr_cycles++;
    end
    resp_ack = resp_wr_en && (wr_cycles >= ack_dly);
    if (done) begin
      chk("done_one_cycle", 128'(done_prev), 128'(0));
      chk("busy_at_done", 128'(busy), 128'(0));
      if (sb.size() == 0) begin
        chk("unexpected_done", 128'(1), 128'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wr_cycles", 128'(wr_cycles), 128'(e.cyc));
        if (e.wr) chk("resp_data", wr_data, e.data);
        chk("err_flags", 128'({timeout_err, crc_err, end_err, idx_err}), 128'(e.errs));
      end
      done_cnt++;
      wr_cycles = 0;
    end
    done_prev = done;
  end

  task automatic strobe(input logic b, input logic inj);
    @(negedge clk);
    start      = 1'b0;
    resp_long  = resp_long & ~inj;
    bit_strobe = 1'b1;
    cmd_in     = b;
    @(negedge clk);
    bit_strobe = 1'b0;
    cmd_in     = 1'b1;
    if (inj) begin
      start     = 1'b1;
      resp_long = 1'b1;   // would corrupt the frame length if accepted
    end
  endtask

  task automatic run_tx(input logic lng, input logic ce, input logic ie, input logic [5:0] idx,
                        input logic [135:0] frame, input int len, input int idle, input int inj_at);
    @(negedge clk);
    start = 1'b1; resp_long = lng; crc_check_en = ce; idx_check_en = ie; cmd_index = idx;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < idle; i++) strobe(1'b1, 1'b0);
    for (int i = len - 1; i >= 0; i--) strobe(frame[i], (len - 1 - i) == inj_at);
    start = 1'b0;
    resp_long = lng;
  endtask

  task automatic expect_tx(input logic [127:0] d, input logic wr, input logic [3:0] errs);
    exp_t e;
    e.data = d; e.wr = wr; e.errs = errs;
    e.cyc  = wr ? ((ack_dly > 2) ? ack_dly : 2) : 0;
    sb.push_back(e);
    exp_done++;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (done_cnt < exp_done && k < 300) begin
      strobe(1'b1, 1'b0);
      k++;
    end
    if (done_cnt < exp_done) chk("done_wait_timeout", 128'(done_cnt), 128'(exp_done));
  endtask

  logic [47:0]  f;
  logic [119:0] pat;
  logic [135:0] lf;
  int           saved;

  initial begin
    rst = 1'b1; start = 1'b0; resp_long = 1'b0; crc_check_en = 1'b0; idx_check_en = 1'b0;
    cmd_index = '0; bit_strobe = 1'b0; cmd_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_wr_en", 128'(resp_wr_en), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_errs", 128'({timeout_err, crc_err, end_err, idx_err}), 128'(0));
    chk("rst_data", resp_data, 128'(0));
    rst = 1'b0;

    // Good short response, idx 17, argument 0x900
    ack_dly = 1;
    f = mk_short(6'd17, 32'h0000_0900, 1'b1, 1'b1);
    expect_tx(128'h900, 1'b1, 4'b0000);
    run_tx(1'b0, 1'b1, 1'b1, 6'd17, 136'(f), 48, 3, -1);
    chk("busy_after_frame", 128'(busy), 128'(1));
    wait_done();

    // Argument bit flipped after CRC was computed
    f[8 + 5] = ~f[8 + 5];
    expect_tx(128'h920, 1'b1, 4'b0100);
    run_tx(1'b0, 1'b1, 1'b1, 6'd17, 136'(f), 48, 2, -1);
    wait_done();

    // No start bit: timeout on the 64th high strobe
    expect_tx(128'h0, 1'b0, 4'b1000);
    run_tx(1'b0, 1'b1, 1'b1, 6'd17, '0, 0, 64, -1);
    wait_done();

    // 63 idle strobes is still in time; slow ack
    ack_dly = 4;
    f = mk_short(6'd17, 32'hDEAD_BEEF, 1'b1, 1'b1);
    expect_tx(128'hDEAD_BEEF, 1'b1, 4'b0000);
    run_tx(1'b0, 1'b1, 1'b1, 6'd17, 136'(f), 48, 63, -1);
    wait_done();
    ack_dly = 1;

    // Long R2: header excluded from CRC, index check masked
    pat = {15{8'hA5}};
    lf  = {8'h3F, pat, crc7_ref(pat, 120), 1'b1};
    expect_tx({8'h00, pat}, 1'b1, 4'b0000);
    run_tx(1'b1, 1'b1, 1'b1, 6'd2, lf, 136, 1, -1);
    wait_done();

    // Index mismatch only
    f = mk_short(6'd17, 32'h0000_0900, 1'b1, 1'b1);
    expect_tx(128'h900, 1'b1, 4'b0001);
    run_tx(1'b0, 1'b1, 1'b1, 6'd18, 136'(f), 48, 0, -1);
    wait_done();

    // R3: CRC field all ones and unchecked, bad end bit
    f = mk_short(6'h3F, 32'h80FF_8000, 1'b0, 1'b0);
    expect_tx(128'h80FF_8000, 1'b1, 4'b0010);
    run_tx(1'b0, 1'b0, 1'b0, 6'd0, 136'(f), 48, 2, -1);
    wait_done();

    // Reset after 20 frame bits aborts with no write and no done
    saved = done_cnt;
    f = mk_short(6'd17, 32'h1234_5678, 1'b1, 1'b1);
    @(negedge clk);
    start = 1'b1; resp_long = 1'b0; crc_check_en = 1'b1; idx_check_en = 1'b1; cmd_index = 6'd17;
    @(negedge clk);
    start = 1'b0;
    for (int i = 47; i >= 28; i--) strobe(f[i], 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_wr_en", 128'(resp_wr_en), 128'(0));
    chk("abort_data", resp_data, 128'(0));
    chk("abort_errs", 128'({timeout_err, crc_err, end_err, idx_err}), 128'(0));
    repeat (10) strobe(1'b1, 1'b0);
    chk("abort_no_done", 128'(done_cnt), 128'(saved));

    // Fresh capture completes; start pulse mid-frame is ignored
    expect_tx(128'h1234_5678, 1'b1, 4'b0000);
    run_tx(1'b0, 1'b1, 1'b1, 6'd17, 136'(f), 48, 1, 30);
    wait_done();

    repeat (5) @(negedge clk);
    chk("sb_empty", 128'(sb.size()), 128'(0));
    chk("done_count", 128'(done_cnt), 128'(exp_done));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sd_resp_capture.md
Name: sd_resp_capture

Overview:
Sequences reception of a command response from the SD CMD line into the 128-bit Response register (offset 010h).
- Deserializes a 48-bit (R1/R3/R6/R7) or 136-bit (R2) response and checks start, end, index and CRC7.
- Maps the payload to the register layout, drives the register's enable, and holds until the register's ack confirms the contents.
- Sits between the CMD-line sampler and reg_010h, under the command FSM.

Parameters:
DATA_WIDTH, 128, width of the Response register payload
NCR_MAX, 64, max bit-strobes of CMD high before the start bit (response timeout)
CNT_W, 8, width of the bit and timeout counters (must hold 136 and NCR_MAX)

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high
start  in  1  1-cycle pulse: arm capture; ignored while busy
resp_long  in  1  1 = 136-bit R2, 0 = 48-bit; sampled at start
crc_check_en  in  1  enable CRC7 check (0 for R3); sampled at start
idx_check_en  in  1  enable index check (short only); sampled at start
cmd_index  in  6  expected command index; sampled at start
bit_strobe  in  1  1-cycle pulse: cmd_in valid this cycle
cmd_in  in  1  synchronized CMD line bit
resp_ack  in  1  ack from Response register (data_in == data_out)
resp_data  out  DATA_WIDTH  payload to Response register
resp_wr_en  out  1  enable to Response register
busy  out  1  capture in progress
done  out  1  1-cycle pulse at end of operation
timeout_err, crc_err, end_err, idx_err  out  1 each  error flags; held until next accepted start

Behaviour:
- Reset (synchronous, active-high): state IDLE, all outputs 0, counters and shift register cleared. Reset mid-operation aborts with no write and no done.
- Only cycles with bit_strobe=1 advance bit logic. Strobes in IDLE, CHECK, WRITE and DONE are ignored.
- IDLE
  - On start: latch the control inputs, clear all error flags, clear the timeout counter, go to WAIT_START.
  - busy=1 from the next cycle.
- WAIT_START
  - Strobe with cmd_in=0: this is the start bit. Shift it in, set bit_cnt=1, seed CRC with it, go to RECV.
  - Strobe with cmd_in=1: increment the timeout counter. When the count reaches NCR_MAX, set timeout_err and go to DONE with no write.
- RECV
  - Each strobe shifts cmd_in in MSB-first and increments bit_cnt.
  - Total length is 48 (short) or 136 (long). After the last bit, go to CHECK.
- CRC7: polynomial x^7+x^3+1, serial, initial 0.
  - Short: covers bits 47..8 (40 bits: start, transmission, index, argument).
  - Long: covers bits 127..8 of the R2 content (120 bits). The 8-bit header is excluded.
  - Received CRC is bits 7..1.
- CHECK (one cycle):
  - end_err = (bit 0 != 1).
  - crc_err = crc_check_en & (computed != received).
  - idx_err = idx_check_en & ~resp_long & (bits[45:40] != cmd_index).
  - Short: resp_data = {96'b0, bits[39:8]}.
  - Long: resp_data = {8'b0, bits[127:8]}.
  - Go to WRITE.
- WRITE: the payload is written even when crc_err, end_err or idx_err is set.
  - resp_wr_en=1 and resp_data held stable.
  - resp_ack is sampled only after at least one cycle with resp_wr_en=1. On the first such cycle with resp_ack=1, drop resp_wr_en and go to DONE.
  - Minimum 2 cycles in WRITE.
- DONE: done=1 for one cycle, busy=0, return to IDLE. Error flags stay valid.
- resp_data holds its last value outside WRITE.
- A start coincident with done is ignored; a new start is accepted from the following cycle.

Decomposition:
- Shared package sd_host_pkg:
  - state encoding (IDLE, WAIT_START, RECV, CHECK, WRITE, DONE)
  - RESP_SHORT_LEN=48, RESP_LONG_LEN=136
  - CRC7_POLY=7'h09
- One sub-module, sd_crc7: serial CRC7 with clear/enable/bit inputs and a 7-bit output, reused by the command transmitter.

Test Plan:
1. Short, checks on, cmd_index=17; 3 idle high strobes, then bits 0x11_00000900_67 (CRC7=0x33, end=1) -> resp_data=0x...0000_0900, resp_wr_en held until ack, done pulse, all errors 0.
2. Same frame with one argument bit flipped -> crc_err=1, resp_data written with the flipped value, done pulse.
3. No start bit: 64 high strobes -> timeout_err=1 on the 64th, resp_wr_en never asserted, done pulse.
4. Long R2: header 0x3F then 120-bit pattern 0xA5A5... with correct CRC7 and end=1 -> resp_data={8'h00, pattern}, crc_err=0. Also run the short frame with idx mismatch (cmd_index=18) -> idx_err=1 only.
5. Short frame with end bit 0 and crc_check_en=0 (R3) -> end_err=1, crc_err=0.
6. rst asserted mid-RECV after 20 bits -> next cycle busy=0, all outputs 0, no write. A subsequent start plus valid frame completes normally. A second start pulse during RECV has no effect.
